// File: rtl/cpcs_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpcs_link_pkg
// Description : Shared constants for the PCS link bring-up sequencer: state
//               encoding, 8b/10b training/idle symbols and word builders.
// Revision    : 1.0 - initial release
// ============================================================================
package cpcs_link_pkg;

    // State encoding, also visible on the STATE output
    localparam logic [2:0] c_ST_OFF        = 3'd0;
    localparam logic [2:0] c_ST_TRAIN      = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ALIGN = 3'd2;
    localparam logic [2:0] c_ST_LOCK       = 3'd3;
    localparam logic [2:0] c_ST_LINK_UP    = 3'd4;

    // 8b/10b symbols used for training and idle fill
    localparam logic [7:0] c_K28_5 = 8'hBC;
    localparam logic [7:0] c_D16_2 = 8'h50;

    // Saturation ceiling of the 16-bit error counter
    localparam logic [15:0] c_CNT16_MAX = 16'hFFFF;

    // Data word for up to 8 byte lanes; bytes above io_size are zero.
    // Training word: K28.5 in every lane. Idle word: K28.5 in lane 0, D16.2 elsewhere.
    function automatic logic [63:0] f_word_data(input int io_size, input logic idle);
        logic [63:0] v_word;
        v_word = '0;
        for (int i = 0; i < 8; i++) begin
            if (i <= io_size) begin
                v_word[i*8 +: 8] = (idle && (i != 0)) ? c_D16_2 : c_K28_5;
            end
        end
        return v_word;
    endfunction

    // K flags matching f_word_data: all lanes K for training, lane 0 only for idle.
    function automatic logic [7:0] f_word_k(input int io_size, input logic idle);
        logic [7:0] v_k;
        v_k = '0;
        for (int i = 0; i < 8; i++) begin
            if (i <= io_size) begin
                v_k[i] = idle ? (i == 0) : 1'b1;
            end
        end
        return v_k;
    endfunction

endpackage : cpcs_link_pkg
`default_nettype wire

// File: rtl/cpcs_link_errmon.sv
`default_nettype none
// ============================================================================
// Module      : cpcs_link_errmon
// Description : Decoder error monitor. Reduces per-byte decoder status to an
//               errored-word flag, keeps a saturating lifetime error count and,
//               while enabled, a windowed error count that raises err_trip.
// Revision    : 1.0 - initial release
// ============================================================================
module cpcs_link_errmon
    import cpcs_link_pkg::*;
#(
    parameter int IO_SIZE    = 1,
    parameter int ERR_WINDOW = 256,
    parameter int ERR_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mon_en,
    input  logic              i_rx_val,
    input  logic [IO_SIZE:0]  i_code_err_n,
    input  logic [IO_SIZE:0]  i_b_cerr,
    input  logic [IO_SIZE:0]  i_rd_err,
    output logic              o_rx_err,
    output logic              o_err_trip,
    output logic [15:0]       o_err_cnt
);

    localparam logic [15:0] c_WIN_LAST = 16'(ERR_WINDOW - 1);
    localparam logic [8:0]  c_THRESH   = 9'(ERR_THRESH);

    logic        w_rx_err;
    logic [8:0]  w_win_sum;
    logic [15:0] r_win_cnt;
    logic [15:0] w_win_cnt_nxt;
    logic [7:0]  r_win_errs;
    logic [7:0]  w_win_errs_nxt;
    logic [15:0] r_err_cnt;
    logic [15:0] w_err_cnt_nxt;

    // Window bookkeeping: the current error joins the compare before the
    // last-cycle clear, and the window idles at zero outside LINK_UP
    always_comb begin
        w_rx_err       = i_rx_val & (~(&i_code_err_n) | (|i_b_cerr) | (|i_rd_err));
        w_win_sum      = {1'b0, r_win_errs} + {8'd0, w_rx_err};
        w_win_cnt_nxt  = r_win_cnt;
        w_win_errs_nxt = r_win_errs;
        w_err_cnt_nxt  = r_err_cnt;

        if (!i_mon_en) begin
            w_win_cnt_nxt  = '0;
            w_win_errs_nxt = '0;
        end else if (r_win_cnt == c_WIN_LAST) begin
            w_win_cnt_nxt  = '0;
            w_win_errs_nxt = '0;
        end else begin
            w_win_cnt_nxt = r_win_cnt + 16'd1;
            if (w_rx_err && (r_win_errs != 8'hFF)) begin
                w_win_errs_nxt = r_win_errs + 8'd1;
            end
        end

        if (w_rx_err && (r_err_cnt != c_CNT16_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt  <= '0;
            r_win_errs <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_win_cnt  <= w_win_cnt_nxt;
            r_win_errs <= w_win_errs_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    assign o_rx_err   = w_rx_err;
    assign o_err_trip = i_mon_en & (w_win_sum >= c_THRESH);
    assign o_err_cnt  = r_err_cnt;

endmodule : cpcs_link_errmon
`default_nettype wire

// File: rtl/cpcs_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpcs_link_ctrl
// Description : Link bring-up and supervision sequencer in front of the PCS
//               8b/10b encoder and word aligner. Trains, waits for alignment,
//               qualifies clean words, then opens the user data path.
// Revision    : 1.0 - initial release
// ============================================================================
module cpcs_link_ctrl
    import cpcs_link_pkg::*;
#(
    parameter int ENDEC_DWIDTH  = 16,
    parameter int IO_SIZE       = (ENDEC_DWIDTH / 8) - 1,
    parameter int WA_RST_CYCLES = 16,
    parameter int ALIGN_TIMEOUT = 4096,
    parameter int LOCK_CNT      = 64,
    parameter int ERR_WINDOW    = 256,
    parameter int ERR_THRESH    = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic [ENDEC_DWIDTH-1:0] USR_TX_DATA,
    input  logic [IO_SIZE:0]        USR_TX_K,
    input  logic                    USR_TX_VALID,
    output logic                    USR_TX_READY,
    output logic [ENDEC_DWIDTH-1:0] TX_DATA,
    output logic [IO_SIZE:0]        TX_K_CHAR,
    output logic                    WA_RSTn,
    input  logic                    RX_VAL,
    input  logic                    ALIGNED,
    input  logic [IO_SIZE:0]        CODE_ERR_N,
    input  logic [IO_SIZE:0]        B_CERR,
    input  logic [IO_SIZE:0]        RD_ERR,
    output logic                    LINK_UP,
    output logic                    LINK_DROP,
    output logic [2:0]              STATE,
    output logic [7:0]              RETRY_CNT,
    output logic [15:0]             ERR_CNT
);

    localparam logic [63:0] c_TRAIN_DATA_W = f_word_data(IO_SIZE, 1'b0);
    localparam logic [63:0] c_IDLE_DATA_W  = f_word_data(IO_SIZE, 1'b1);
    localparam logic [7:0]  c_TRAIN_K_W    = f_word_k(IO_SIZE, 1'b0);
    localparam logic [7:0]  c_IDLE_K_W     = f_word_k(IO_SIZE, 1'b1);

    localparam logic [ENDEC_DWIDTH-1:0] c_TRAIN_DATA = c_TRAIN_DATA_W[ENDEC_DWIDTH-1:0];
    localparam logic [ENDEC_DWIDTH-1:0] c_IDLE_DATA  = c_IDLE_DATA_W[ENDEC_DWIDTH-1:0];
    localparam logic [IO_SIZE:0]        c_TRAIN_K    = c_TRAIN_K_W[IO_SIZE:0];
    localparam logic [IO_SIZE:0]        c_IDLE_K     = c_IDLE_K_W[IO_SIZE:0];

    localparam logic [7:0]  c_WA_LAST   = 8'(WA_RST_CYCLES - 1);
    localparam logic [15:0] c_TO_LAST   = 16'(ALIGN_TIMEOUT - 1);
    localparam logic [15:0] c_LOCK_LAST = 16'(LOCK_CNT - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [7:0]              r_wa_cnt;
    logic [7:0]              w_wa_cnt_nxt;
    logic [15:0]             r_to_cnt;
    logic [15:0]             w_to_cnt_nxt;
    logic [15:0]             r_lock_cnt;
    logic [15:0]             w_lock_cnt_nxt;
    logic                    w_timeout;
    logic                    w_lock_clean;
    logic                    w_rx_err;
    logic                    w_err_trip;
    logic                    w_accept;

    logic [ENDEC_DWIDTH-1:0] r_tx_data;
    logic [ENDEC_DWIDTH-1:0] w_tx_data_nxt;
    logic [IO_SIZE:0]        r_tx_k;
    logic [IO_SIZE:0]        w_tx_k_nxt;
    logic                    r_wa_rstn;
    logic                    r_ready;
    logic                    r_link_drop;
    logic [7:0]              r_retry_cnt;
    logic [7:0]              w_retry_cnt_nxt;

    cpcs_link_errmon #(
        .IO_SIZE    (IO_SIZE),
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_errmon (
        .clk          (CLK),
        .rst          (RESET),
        .i_mon_en     (r_state == c_ST_LINK_UP),
        .i_rx_val     (RX_VAL),
        .i_code_err_n (CODE_ERR_N),
        .i_b_cerr     (B_CERR),
        .i_rd_err     (RD_ERR),
        .o_rx_err     (w_rx_err),
        .o_err_trip   (w_err_trip),
        .o_err_cnt    (ERR_CNT)
    );

    // Next-state and per-state counters; EN low overrides every transition
    always_comb begin
        w_state_nxt    = r_state;
        w_wa_cnt_nxt   = r_wa_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_lock_cnt_nxt = r_lock_cnt;
        w_timeout      = 1'b0;
        w_lock_clean   = RX_VAL & ~w_rx_err;

        case (r_state)
            c_ST_OFF: begin
                if (EN) w_state_nxt = c_ST_TRAIN;
            end
            c_ST_TRAIN: begin
                w_wa_cnt_nxt = r_wa_cnt + 8'd1;
                if (r_wa_cnt == c_WA_LAST) w_state_nxt = c_ST_WAIT_ALIGN;
            end
            c_ST_WAIT_ALIGN: begin
                w_to_cnt_nxt = r_to_cnt + 16'd1;
                if (ALIGNED) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nxt = c_ST_TRAIN;
                    w_timeout   = 1'b1;
                end
            end
            c_ST_LOCK: begin
                if (w_rx_err) begin
                    w_lock_cnt_nxt = '0;
                end else if (RX_VAL) begin
                    w_lock_cnt_nxt = r_lock_cnt + 16'd1;
                end
                if (!ALIGNED) begin
                    w_state_nxt = c_ST_TRAIN;
                end else if (w_lock_clean && (r_lock_cnt == c_LOCK_LAST)) begin
                    w_state_nxt = c_ST_LINK_UP;
                end
            end
            c_ST_LINK_UP: begin
                if (!ALIGNED || w_err_trip) w_state_nxt = c_ST_TRAIN;
            end
            default: begin
                w_state_nxt = c_ST_OFF;
            end
        endcase

        if (!EN) begin
            w_state_nxt = c_ST_OFF;
            w_timeout   = 1'b0;
        end

        if (w_state_nxt != r_state) begin
            w_wa_cnt_nxt   = '0;
            w_to_cnt_nxt   = '0;
            w_lock_cnt_nxt = '0;
        end
    end

    // Encoder word selection and retry accounting; an accepted user word
    // always goes out next cycle, even if the link is leaving LINK_UP
    always_comb begin
        w_accept        = USR_TX_VALID & r_ready;
        w_tx_data_nxt   = c_TRAIN_DATA;
        w_tx_k_nxt      = c_TRAIN_K;
        w_retry_cnt_nxt = r_retry_cnt;

        if (w_accept) begin
            w_tx_data_nxt = USR_TX_DATA;
            w_tx_k_nxt    = USR_TX_K;
        end else if ((w_state_nxt == c_ST_LOCK) || (w_state_nxt == c_ST_LINK_UP)) begin
            w_tx_data_nxt = c_IDLE_DATA;
            w_tx_k_nxt    = c_IDLE_K;
        end

        if (w_timeout && (r_retry_cnt != 8'hFF)) begin
            w_retry_cnt_nxt = r_retry_cnt + 8'd1;
        end
    end

    // State, counter and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= c_ST_OFF;
            r_wa_cnt    <= '0;
            r_to_cnt    <= '0;
            r_lock_cnt  <= '0;
            r_tx_data   <= c_TRAIN_DATA;
            r_tx_k      <= c_TRAIN_K;
            r_wa_rstn   <= 1'b0;
            r_ready     <= 1'b0;
            r_link_drop <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wa_cnt    <= w_wa_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_k      <= w_tx_k_nxt;
            r_wa_rstn   <= (w_state_nxt != c_ST_OFF) && (w_state_nxt != c_ST_TRAIN);
            r_ready     <= (w_state_nxt == c_ST_LINK_UP);
            r_link_drop <= (r_state == c_ST_LINK_UP) && (w_state_nxt != c_ST_LINK_UP);
            r_retry_cnt <= w_retry_cnt_nxt;
        end
    end

    assign STATE        = r_state;
    assign TX_DATA      = r_tx_data;
    assign TX_K_CHAR    = r_tx_k;
    assign WA_RSTn      = r_wa_rstn;
    assign USR_TX_READY = r_ready;
    assign LINK_UP      = r_ready;
    assign LINK_DROP    = r_link_drop;
    assign RETRY_CNT    = r_retry_cnt;

endmodule : cpcs_link_ctrl
`default_nettype wire

// File: tb/tb_cpcs_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpcs_link_ctrl
// Description : Directed self-checking bench for cpcs_link_ctrl with default
//               parameters (16-bit datapath).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpcs_link_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        EN = 1'b0;
    logic [15:0] USR_TX_DATA = '0;
    logic [1:0]  USR_TX_K = '0;
    logic        USR_TX_VALID = 1'b0;
    logic        USR_TX_READY;
    logic [15:0] TX_DATA;
    logic [1:0]  TX_K_CHAR;
    logic        WA_RSTn;
    logic        RX_VAL = 1'b1;
    logic        ALIGNED = 1'b0;
    logic [1:0]  CODE_ERR_N = 2'b11;
    logic [1:0]  B_CERR = 2'b00;
    logic [1:0]  RD_ERR = 2'b00;
    logic        LINK_UP;
    logic        LINK_DROP;
    logic [2:0]  STATE;
    logic [7:0]  RETRY_CNT;
    logic [15:0] ERR_CNT;

    int checks = 0;
    int failures = 0;

    cpcs_link_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .EN           (EN),
        .USR_TX_DATA  (USR_TX_DATA),
        .USR_TX_K     (USR_TX_K),
        .USR_TX_VALID (USR_TX_VALID),
        .USR_TX_READY (USR_TX_READY),
        .TX_DATA      (TX_DATA),
        .TX_K_CHAR    (TX_K_CHAR),
        .WA_RSTn      (WA_RSTn),
        .RX_VAL       (RX_VAL),
        .ALIGNED      (ALIGNED),
        .CODE_ERR_N   (CODE_ERR_N),
        .B_CERR       (B_CERR),
        .RD_ERR       (RD_ERR),
        .LINK_UP      (LINK_UP),
        .LINK_DROP    (LINK_DROP),
        .STATE        (STATE),
        .RETRY_CNT    (RETRY_CNT),
        .ERR_CNT      (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // One clock; outputs are observed and inputs changed 1 ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic aligned);
        RESET = 1'b1; EN = 1'b0; ALIGNED = aligned; RX_VAL = 1'b1;
        CODE_ERR_N = 2'b11; B_CERR = 2'b00; RD_ERR = 2'b00; USR_TX_VALID = 1'b0;
        repeat (3) tick();
        RESET = 1'b0; EN = 1'b1;
    endtask

    // Reset, train with ALIGNED high, and stop in the first LINK_UP cycle
    task automatic bring_up(output bit ok);
        apply_reset(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (STATE == 3'd4) ok = 1'b1;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (STATE == st) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; EN = 1'b0;
        repeat (3) tick();
        checks++; if (STATE !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d exp 0", STATE); end
        checks++; if (TX_DATA !== 16'hBCBC || TX_K_CHAR !== 2'b11) begin failures++; $display("FAIL reset_tx: got %h/%b exp bcbc/11", TX_DATA, TX_K_CHAR); end
        checks++; if (WA_RSTn !== 1'b0 || USR_TX_READY !== 1'b0 || LINK_UP !== 1'b0 || LINK_DROP !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got wa=%b rdy=%b up=%b drop=%b exp 0000", WA_RSTn, USR_TX_READY, LINK_UP, LINK_DROP); end
        checks++; if (RETRY_CNT !== 8'd0 || ERR_CNT !== 16'd0) begin failures++; $display("FAIL reset_cnts: got retry=%0d err=%0d exp 0/0", RETRY_CNT, ERR_CNT); end
    endtask

    task automatic test_bringup();
        int n_cyc, n_low, bad_tx;
        RESET = 1'b0; EN = 1'b1; ALIGNED = 1'b0;
        tick();
        checks++; if (STATE !== 3'd1) begin failures++; $display("FAIL bringup_train: got %0d exp 1", STATE); end
        n_cyc = 0; n_low = 0; bad_tx = 0;
        while (STATE == 3'd1 && n_cyc < 100) begin
            if (WA_RSTn == 1'b0) n_low++;
            if (TX_DATA !== 16'hBCBC || TX_K_CHAR !== 2'b11) bad_tx++;
            tick(); n_cyc++;
        end
        checks++; if (n_cyc != 16 || n_low != 16) begin failures++; $display("FAIL bringup_wa_rst: got cycles=%0d low=%0d exp 16/16", n_cyc, n_low); end
        checks++; if (bad_tx != 0) begin failures++; $display("FAIL bringup_train_word: got %0d bad words exp 0", bad_tx); end
        checks++; if (STATE !== 3'd2 || WA_RSTn !== 1'b1) begin failures++; $display("FAIL bringup_wait: got st=%0d wa=%b exp 2/1", STATE, WA_RSTn); end
        repeat (10) tick();
        checks++; if (STATE !== 3'd2 || TX_DATA !== 16'hBCBC || TX_K_CHAR !== 2'b11) begin
            failures++; $display("FAIL bringup_wait_tx: got st=%0d %h/%b exp 2 bcbc/11", STATE, TX_DATA, TX_K_CHAR); end
        ALIGNED = 1'b1;
        tick();
        checks++; if (STATE !== 3'd3 || TX_DATA !== 16'h50BC || TX_K_CHAR !== 2'b01) begin
            failures++; $display("FAIL bringup_lock: got st=%0d %h/%b exp 3 50bc/01", STATE, TX_DATA, TX_K_CHAR); end
        repeat (63) tick();
        checks++; if (STATE !== 3'd3) begin failures++; $display("FAIL bringup_lock63: got %0d exp 3", STATE); end
        tick();
        checks++; if (STATE !== 3'd4 || LINK_UP !== 1'b1 || USR_TX_READY !== 1'b1) begin
            failures++; $display("FAIL bringup_linkup: got st=%0d up=%b rdy=%b exp 4/1/1", STATE, LINK_UP, USR_TX_READY); end
    endtask

    task automatic test_datapath();
        USR_TX_DATA = 16'h1234; USR_TX_K = 2'b00; USR_TX_VALID = 1'b1;
        tick();
        USR_TX_VALID = 1'b0;
        checks++; if (TX_DATA !== 16'h1234 || TX_K_CHAR !== 2'b00) begin failures++; $display("FAIL data_word: got %h/%b exp 1234/00", TX_DATA, TX_K_CHAR); end
        tick();
        checks++; if (TX_DATA !== 16'h50BC || TX_K_CHAR !== 2'b01) begin failures++; $display("FAIL data_idle: got %h/%b exp 50bc/01", TX_DATA, TX_K_CHAR); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n_low;
        apply_reset(1'b0);
        wait_state(3'd2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_reach_wait: got st=%0d exp 2", STATE); end
        repeat (4095) tick();
        checks++; if (STATE !== 3'd2) begin failures++; $display("FAIL to_early: got %0d exp 2", STATE); end
        tick();
        checks++; if (STATE !== 3'd1 || RETRY_CNT !== 8'd1 || WA_RSTn !== 1'b0) begin
            failures++; $display("FAIL to_first: got st=%0d retry=%0d wa=%b exp 1/1/0", STATE, RETRY_CNT, WA_RSTn); end
        n_low = 0;
        for (int i = 0; i < 100 && STATE == 3'd1; i++) begin
            if (WA_RSTn == 1'b0) n_low++;
            tick();
        end
        checks++; if (n_low != 16 || STATE !== 3'd2) begin failures++; $display("FAIL to_wa_pulse: got low=%0d st=%0d exp 16/2", n_low, STATE); end
        repeat (4096) tick();
        checks++; if (STATE !== 3'd1 || RETRY_CNT !== 8'd2) begin failures++; $display("FAIL to_second: got st=%0d retry=%0d exp 1/2", STATE, RETRY_CNT); end
        wait_state(3'd2, ok);
        repeat (4095) tick();
        ALIGNED = 1'b1;
        tick();
        checks++; if (STATE !== 3'd3 || RETRY_CNT !== 8'd2) begin failures++; $display("FAIL to_aligned_wins: got st=%0d retry=%0d exp 3/2", STATE, RETRY_CNT); end
    endtask

    task automatic test_lock_restart();
        bit ok;
        apply_reset(1'b1);
        wait_state(3'd3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lr_reach_lock: got st=%0d exp 3", STATE); end
        for (int i = 0; i < 127; i++) begin
            RD_ERR = (i == 62) ? 2'b10 : 2'b00;
            if (i == 126) begin
                checks++; if (STATE !== 3'd3) begin failures++; $display("FAIL lr_still_lock: got %0d exp 3", STATE); end
            end
            tick();
        end
        RD_ERR = 2'b00;
        checks++; if (STATE !== 3'd4) begin failures++; $display("FAIL lr_linkup: got %0d exp 4", STATE); end
        checks++; if (ERR_CNT !== 16'd1) begin failures++; $display("FAIL lr_err_cnt: got %0d exp 1", ERR_CNT); end
    endtask

    task automatic test_err_trip();
        bit ok;
        int drops;
        // Four errors inside one window
        bring_up(ok);
        checks++; if (!ok) begin failures++; $display("FAIL trip_a_bringup: got st=%0d exp 4", STATE); end
        for (int i = 0; i < 41; i++) begin
            CODE_ERR_N = (i == 10 || i == 20 || i == 30 || i == 40) ? 2'b10 : 2'b11;
            if (i == 40) begin
                checks++; if (STATE !== 3'd4) begin failures++; $display("FAIL trip_a_early: got %0d exp 4", STATE); end
            end
            tick();
        end
        CODE_ERR_N = 2'b11;
        checks++; if (STATE !== 3'd1 || LINK_DROP !== 1'b1 || USR_TX_READY !== 1'b0) begin
            failures++; $display("FAIL trip_a_drop: got st=%0d drop=%b rdy=%b exp 1/1/0", STATE, LINK_DROP, USR_TX_READY); end
        checks++; if (ERR_CNT !== 16'd4) begin failures++; $display("FAIL trip_a_err_cnt: got %0d exp 4", ERR_CNT); end
        tick();
        checks++; if (LINK_DROP !== 1'b0) begin failures++; $display("FAIL trip_a_pulse: got %b exp 0", LINK_DROP); end

        // Three errors either side of the window boundary: no trip
        bring_up(ok);
        drops = 0;
        for (int i = 0; i < 262; i++) begin
            CODE_ERR_N = ((i >= 250 && i <= 252) || (i >= 256 && i <= 258)) ? 2'b10 : 2'b11;
            tick();
            if (LINK_DROP) drops++;
        end
        CODE_ERR_N = 2'b11;
        checks++; if (drops != 0 || STATE !== 3'd4) begin failures++; $display("FAIL trip_b_nodrop: got drops=%0d st=%0d exp 0/4", drops, STATE); end
        checks++; if (ERR_CNT !== 16'd6) begin failures++; $display("FAIL trip_b_err_cnt: got %0d exp 6", ERR_CNT); end

        // Fourth error on the window's last cycle still counts toward the trip
        bring_up(ok);
        for (int i = 0; i < 256; i++) begin
            CODE_ERR_N = ((i >= 250 && i <= 252) || i == 255) ? 2'b10 : 2'b11;
            tick();
        end
        CODE_ERR_N = 2'b11;
        checks++; if (STATE !== 3'd1 || LINK_DROP !== 1'b1) begin failures++; $display("FAIL trip_c_last: got st=%0d drop=%b exp 1/1", STATE, LINK_DROP); end
    endtask

    task automatic test_priority();
        bit ok;
        bring_up(ok);
        repeat (5) tick();
        EN = 1'b0; ALIGNED = 1'b0;
        USR_TX_DATA = 16'hA5C3; USR_TX_K = 2'b10; USR_TX_VALID = 1'b1;
        tick();
        USR_TX_VALID = 1'b0;
        checks++; if (STATE !== 3'd0 || LINK_DROP !== 1'b1 || USR_TX_READY !== 1'b0) begin
            failures++; $display("FAIL prio_off: got st=%0d drop=%b rdy=%b exp 0/1/0", STATE, LINK_DROP, USR_TX_READY); end
        checks++; if (TX_DATA !== 16'hA5C3 || TX_K_CHAR !== 2'b10) begin failures++; $display("FAIL prio_last_word: got %h/%b exp a5c3/10", TX_DATA, TX_K_CHAR); end
        tick();
        checks++; if (LINK_DROP !== 1'b0 || STATE !== 3'd0 || TX_DATA !== 16'hBCBC) begin
            failures++; $display("FAIL prio_after: got drop=%b st=%0d tx=%h exp 0/0/bcbc", LINK_DROP, STATE, TX_DATA); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bring_up(ok);
        CODE_ERR_N = 2'b10;
        tick();
        CODE_ERR_N = 2'b11;
        checks++; if (ERR_CNT !== 16'd1 || STATE !== 3'd4) begin failures++; $display("FAIL rm_pre: got err=%0d st=%0d exp 1/4", ERR_CNT, STATE); end
        RESET = 1'b1;
        tick();
        checks++; if (STATE !== 3'd0 || LINK_DROP !== 1'b0 || ERR_CNT !== 16'd0 || USR_TX_READY !== 1'b0 || WA_RSTn !== 1'b0) begin
            failures++; $display("FAIL rm_reset: got st=%0d drop=%b err=%0d rdy=%b wa=%b exp 0/0/0/0/0", STATE, LINK_DROP, ERR_CNT, USR_TX_READY, WA_RSTn); end
        RESET = 1'b0; EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_datapath();
        test_lock_restart();
        test_timeout();
        test_err_trip();
        test_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cpcs_link_ctrl
`default_nettype wire
